vector_argmax: RTL



---
 rtl/vector_argmax_pkg.sv | 41 ++++
 rtl/vector_argmax_if.sv | 36 +++
 rtl/vector_argmax_fp32_gt.sv | 18 +
 rtl/vector_argmax.sv | 114 +++++++++++
 4 files changed

// File: rtl/vector_argmax_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_argmax_pkg
// Description : Shared FP32 types, FSM state encoding and ordering helpers
//               for the argmax stage (and the comparator it shares).
// Revision    : 1.0 - initial release
// ============================================================================
package vector_argmax_pkg;

    typedef logic [31:0] fp32_t;

    localparam logic [7:0]  FP32_EXP_ONES  = 8'hFF;
    localparam logic [31:0] FP32_NEG_ZERO  = 32'h8000_0000;
    localparam logic [31:0] FP32_SIGN_MASK = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index width, never narrower than one bit so VECTOR_LEN=1 still works.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // NaN: exponent all ones with a non-zero mantissa.
    function automatic logic fp32_is_nan(input fp32_t x);
        return (x[30:23] == FP32_EXP_ONES) && (x[22:0] != 23'd0);
    endfunction

    // Monotonic unsigned key: -0 folds onto +0, negatives are bit-inverted
    // so larger magnitude sorts lower, positives get the top bit set.
    function automatic logic [31:0] fp32_order_key(input fp32_t x);
        fp32_t n;
        n = (x == FP32_NEG_ZERO) ? 32'h0000_0000 : x;
        return n[31] ? ~n : (n | FP32_SIGN_MASK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_argmax_if.sv
`default_nettype none
// ============================================================================
// Module      : vector_argmax_if
// Description : Input-vector and result handshake bundle for vector_argmax.
// Revision    : 1.0 - initial release
// ============================================================================
interface vector_argmax_if
    import vector_argmax_pkg::*;
#(
    parameter int VECTOR_LEN = 4,
    parameter int DATA_WIDTH = 32
) ();
    localparam int IDX_W = idx_width(VECTOR_LEN);

    logic                             in_valid;
    logic                             in_ready;
    logic [VECTOR_LEN*DATA_WIDTH-1:0] in_data;
    logic                             out_valid;
    logic                             out_ready;
    logic [IDX_W-1:0]                 out_index;
    logic [DATA_WIDTH-1:0]            out_value;
    logic                             out_all_nan;

    // Producer of vectors / consumer of results.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_value, out_all_nan
    );

    // The argmax block itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_value, out_all_nan
    );
endinterface
`default_nettype wire

// File: rtl/vector_argmax_fp32_gt.sv
`default_nettype none
// ============================================================================
// Module      : fp32_gt
// Description : Combinational FP32 strict greater-than on non-NaN operands;
//               -0 and +0 compare equal, infinities order naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_gt
    import vector_argmax_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output logic  a_gt_b
);
    // Unsigned compare of the order keys gives the IEEE ordering.
    assign a_gt_b = (fp32_order_key(a) > fp32_order_key(b));
endmodule
`default_nettype wire

// File: rtl/vector_argmax.sv
`default_nettype none
// ============================================================================
// Module      : vector_argmax
// Description : Sequential argmax over an FP32 vector, one element per clock.
//               NaNs are skipped; ties resolve to the lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_argmax
    import vector_argmax_pkg::*;
#(
    parameter int VECTOR_LEN = 4,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    vector_argmax_if.slave   bus
);
    localparam int IDX_W = idx_width(VECTOR_LEN);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(VECTOR_LEN - 1);

    state_t           r_state;
    state_t           w_state_next;
    fp32_t            r_vec [VECTOR_LEN];
    logic [IDX_W-1:0] r_idx;
    logic             r_have_max;
    logic [IDX_W-1:0] r_max_idx;
    fp32_t            r_max_val;

    fp32_t            w_elem;
    logic             w_elem_gt;
    logic             w_take;
    logic             w_have_next;
    logic [IDX_W-1:0] w_max_idx_next;
    fp32_t            w_max_val_next;
    logic             w_last;
    logic             w_accept;

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign w_accept      = bus.in_valid && (r_state == ST_IDLE);

    assign w_elem = r_vec[r_idx];
    assign w_last = (r_idx == c_last_idx);

    fp32_gt u_gt (
        .a      (w_elem),
        .b      (r_max_val),
        .a_gt_b (w_elem_gt)
    );

    // Running-max update for the element under evaluation this cycle.
    assign w_take         = !fp32_is_nan(w_elem) && (!r_have_max || w_elem_gt);
    assign w_have_next    = r_have_max || w_take;
    assign w_max_idx_next = w_take ? r_idx  : r_max_idx;
    assign w_max_val_next = w_take ? w_elem : r_max_val;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)      w_state_next = ST_SCAN;
            ST_SCAN: if (w_last)        w_state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    // Vector capture, scan counter, running max and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx           <= '0;
            r_have_max      <= 1'b0;
            r_max_idx       <= '0;
            r_max_val       <= '0;
            bus.out_index   <= '0;
            bus.out_value   <= '0;
            bus.out_all_nan <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        for (int i = 0; i < VECTOR_LEN; i++) begin
                            r_vec[i] <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        r_idx      <= '0;
                        r_have_max <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    r_have_max <= w_have_next;
                    r_max_idx  <= w_max_idx_next;
                    r_max_val  <= w_max_val_next;
                    if (w_last) begin
                        // An all-NaN vector reports element 0 verbatim.
                        bus.out_index   <= w_have_next ? w_max_idx_next : '0;
                        bus.out_value   <= w_have_next ? w_max_val_next : r_vec[0];
                        bus.out_all_nan <= !w_have_next;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
